// File: rtl/gcd_engine.sv
// gcd_engine: subtractive GCD unit with start/done handshake.
// Ports: clk, rst_n, start, a_in, b_in -> busy, done, result, iter_count, err_zero.
module gcd_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] iter_count,
    output logic             err_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] iter_q, iter_d;
    logic             err_q, err_d;

    logic a_zero, b_zero;

    assign a_zero = (a_q == '0);
    assign b_zero = (b_q == '0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        iter_d   = iter_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // One decision per cycle; the larger value is always the
                // minuend, so the subtraction cannot wrap.
                if (a_zero && b_zero) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else if (b_zero) begin
                    result_d = a_q;
                    state_d  = DONE;
                end else if (a_zero) begin
                    result_d = b_q;
                    state_d  = DONE;
                end else if (a_q == b_q) begin
                    result_d = a_q;
                    state_d  = DONE;
                end else if (a_q > b_q) begin
                    a_d    = a_q - b_q;
                    iter_d = iter_q + WIDTH'(1);
                end else begin
                    b_d    = b_q - a_q;
                    iter_d = iter_q + WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            iter_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            iter_q   <= iter_d;
            err_q    <= err_d;
        end
    end

    // Status decoded from registered state only.
    assign busy       = (state_q == CALC);
    assign done       = (state_q == DONE);
    assign result     = result_q;
    assign iter_count = iter_q;
    assign err_zero   = err_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: table-driven and scoreboard bench for gcd_engine.
// Drives a WIDTH=16 instance and a WIDTH=8 instance for the worst case.
module tb_gcd_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in, b_in;
    logic        busy, done, err_zero;
    logic [15:0] result, iter_count;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, err8;
    logic [7:0]  result8, iter8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] iter;
        logic        err;
        int          n;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [15:0] iter;
        logic        err;
    } exp_t;

    exp_t sb[$];

    gcd_engine #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result),
        .iter_count(iter_count), .err_zero(err_zero)
    );

    gcd_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .result(result8),
        .iter_count(iter8), .err_zero(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run16(input vec_t v);
        exp_t e;
        int   busy_cnt;
        bit   got;
        @(negedge clk);
        a_in  = v.a;
        b_in  = v.b;
        start = 1'b1;
        sb.push_back('{res: v.res, iter: v.iter, err: v.err});
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cnt = 0;
        got = 1'b0;
        for (int c = 1; c <= v.n + 10 && !got; c++) begin
            @(negedge clk);
            if (c == 1) chk("err_clear_on_accept", err_zero, 0);
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("iter_count", iter_count, e.iter);
                chk("err_zero", err_zero, e.err);
                chk("done_latency", c, v.n + 2);
                chk("busy_cycles", busy_cnt, v.n + 1);
            end
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
    endtask

    vec_t tbl[7];

    initial begin
        int   done_cnt;
        int   first_done, second_done;
        bit   wrap_seen, got;
        logic [7:0] prev_iter;

        tbl[0] = '{a: 12, b: 18, res: 6, iter: 2, err: 0, n: 2};
        tbl[1] = '{a: 17, b: 5,  res: 1, iter: 6, err: 0, n: 6};
        tbl[2] = '{a: 7,  b: 7,  res: 7, iter: 0, err: 0, n: 0};
        tbl[3] = '{a: 0,  b: 5,  res: 5, iter: 0, err: 0, n: 0};
        tbl[4] = '{a: 9,  b: 0,  res: 9, iter: 0, err: 0, n: 0};
        tbl[5] = '{a: 0,  b: 0,  res: 0, iter: 0, err: 1, n: 0};
        tbl[6] = '{a: 4,  b: 6,  res: 2, iter: 2, err: 0, n: 2};

        rst_n = 1'b0;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
        start8 = 1'b0;
        a8 = '0;
        b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_iter", iter_count, 0);
        chk("reset_err", err_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run16(tbl[i]);

        // Idle hold: outputs keep last values.
        repeat (3) @(negedge clk);
        chk("idle_hold_result", result, 2);
        chk("idle_hold_iter", iter_count, 2);

        // Worst case on WIDTH=8.
        @(negedge clk);
        a8 = 8'd1;
        b8 = 8'd255;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        got = 1'b0;
        wrap_seen = 1'b0;
        prev_iter = 8'd0;
        for (int c = 1; c <= 300 && !got; c++) begin
            @(negedge clk);
            if (iter8 < prev_iter) wrap_seen = 1'b1;
            prev_iter = iter8;
            if (done8) begin
                got = 1'b1;
                chk("w8_result", result8, 1);
                chk("w8_iter", iter8, 254);
                chk("w8_latency", c, 256);
            end
        end
        chk("w8_done_seen", got, 1);
        chk("w8_no_wrap", wrap_seen, 0);

        // Start pulsed during CALC is ignored.
        @(negedge clk);
        a_in = 16'd12;
        b_in = 16'd18;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        a_in = 16'd3;
        b_in = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                chk("ignore_start_result", result, 6);
            end
        end
        chk("ignore_start_done_count", done_cnt, 1);

        // Start held high: accepts every N+3 cycles.
        @(negedge clk);
        a_in = 16'd12;
        b_in = 16'd18;
        start = 1'b1;
        first_done = -1;
        second_done = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
                chk("held_start_result", result, 6);
            end
        end
        start = 1'b0;
        chk("held_first_done", first_done, 4);
        chk("held_second_done", second_done, 9);
        repeat (8) @(negedge clk);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        a_in = 16'd1;
        b_in = 16'd255;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_iter", iter_count, 0);
        chk("arst_err", err_zero, 0);
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("arst_no_done", done_cnt, 0);
        run16(tbl[0]);

        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
